bias_adder: RTL and testbench
=============================

# bias_adder

Read-side companion of the bias buffer, sitting between the convolution accumulators and the activation/requantisation stage. Per layer it steps the bias buffer read address through the output-channel groups, one group of 8 channels per address, and waits out the RAM read latency. It latches the 8 biases and adds them, with signed saturation, to every accumulator beat of that group. Output is one registered stream with group/layer framing.

## Interface
Parameters:
- `RD_LAT`, 1: bias RAM read latency in cycles, from `bias_rd_addr` change to valid `bias_chN`.
- `GRP_W`, 7: width of the group index; matches the bias buffer read address.

Ports:
- `sclk`  in  1  sole clock
- `s_rst_n`  in  1  asynchronous, active-low reset
- `layer_start`  in  1  one-cycle pulse that begins a layer; honoured only in IDLE
- `grp_num`  in  GRP_W  number of output-channel groups minus 1; sampled on an accepted `layer_start`
- `bias_rd_addr`  out  GRP_W  bias buffer read address (registered)
- `bias_ch0`..`bias_ch7`  in  32 each  signed biases from the bias buffer
- `acc_vld`  in  1  accumulator beat valid
- `acc_last`  in  1  last beat of the current group; qualified by `acc_vld`
- `acc_data`  in  256  8 signed 32-bit sums; channel k is at [32k+31:32k]
- `acc_rdy`  out  1  beat accepted when `acc_vld && acc_rdy`
- `out_vld`  out  1  result beat valid
- `out_last`  out  1  last beat of a group
- `out_data`  out  256  8 saturated sums, same packing as `acc_data`
- `layer_done`  out  1  one-cycle pulse, coincident with the final `out_last`
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, PREFETCH, RUN, DONE.
- IDLE: waits for `layer_start`.
  - On `layer_start`: latch `grp_num`, set `grp_cnt`=0 and `bias_rd_addr`=0, go to PREFETCH.
- PREFETCH: a wait counter runs `RD_LAT`+1 cycles.
  - On the last wait cycle, capture `bias_ch0`..`bias_ch7` into `bias_reg`, then go to RUN.
- RUN: `acc_rdy`=1. Each accepted beat gives `out_data[k]` = sat32(`acc_data[k]` + `bias_reg[k]`); `out_last` = `acc_last`.
  - Accepted beat with `acc_last`=1 and `grp_cnt`==`grp_num`: go to DONE.
  - Accepted beat with `acc_last`=1 otherwise: `grp_cnt`+1, `bias_rd_addr`+1, go to PREFETCH.
- DONE: lasts one cycle, then IDLE.
- `acc_rdy`=0 in IDLE, PREFETCH and DONE. Upstream holds the beat until it is accepted; there is no data loss across group switches.
- Arithmetic: 33-bit signed sum.
  - Greater than 0x7FFFFFFF clips to 0x7FFFFFFF.
  - Less than -2^31 clips to 0x80000000.
  - No rounding.
- `layer_start` outside IDLE is ignored and does not restart the layer.
- `acc_vld` outside RUN is not accepted and has no effect.
- Counter bounds: `bias_rd_addr` never exceeds `grp_num`.
  - `grp_num`=0 gives a single group, address 0 only.
  - `grp_num`=2^GRP_W−1 uses the full address range with no wrap.
- Reset, at any time including mid-layer:
  - State goes to IDLE.
  - `bias_rd_addr`, `grp_cnt`, `bias_reg`, `out_data` = 0.
  - `acc_rdy`, `out_vld`, `out_last`, `layer_done`, `busy` = 0.
  - Any partially processed layer is discarded.

## Timing
- All outputs are registered and update on the rising edge of `sclk`.
- `layer_start` at edge t:
  - `bias_rd_addr`=0 and `busy`=1 from t+1.
  - `acc_rdy`=1 from t+RD_LAT+2.
- Beat accepted at edge t: `out_vld`/`out_data`/`out_last` valid during cycle t+1. Latency is 1 and throughput is 1 beat/cycle in RUN.
- Group switch: the beat carrying `acc_last` is accepted at edge t.
  - `bias_rd_addr` increments at t+1.
  - `acc_rdy` is low from t+1 and high again from t+RD_LAT+3, giving RD_LAT+2 bubble cycles.
- Final `acc_last` accepted at edge t: `out_last` and `layer_done` high together during t+1; `busy` falls at t+2.
- No backpressure on the output: downstream always accepts.

## Structure
- Shared package holds:
  - FSM state encoding (2-bit localparams).
  - `CH_NUM`=8 and `DW`=32.
  - A `sat_add32` function, reused by the requantisation stage.
- One sub-module is natural: `sat_add32`, a combinational saturating adder instantiated 8 times.
- The FSM, counters and output registers stay in `bias_adder`.

## Test plan
- Single group, `grp_num`=0, RD_LAT=1, `bias_ch0..7`=1..8, 4 beats of all-100 with the 4th `acc_last` -> `out_data` ch k = 101+k for 4 beats; `out_last`/`layer_done` on beat 4; `bias_rd_addr` stays 0.
- Three groups (`grp_num`=2), biases per address 10/20/30 -> addresses 0,1,2 in order; each group's outputs use its own bias; RD_LAT+2 cycle `acc_rdy` gap between groups; `layer_done` once.
- Saturation: acc 0x7FFFFFF0 + bias 0x20 -> 0x7FFFFFFF; acc 0x80000010 + bias 0xFFFFFFE0 (−32) -> 0x80000000; acc −5 + bias 5 -> 0.
- Handshake: `acc_vld` held high through PREFETCH with a fixed beat -> no output until RUN; the beat is emitted exactly once.
- `layer_start` pulsed during RUN with a different `grp_num` -> ignored; the layer completes with the original group count.
- `s_rst_n` asserted mid-group 1 of 3 -> all outputs 0 immediately; a new `layer_start` afterwards restarts from address 0 with correct results.

Source files
------------

// File: rtl/bias_adder_pkg.sv
// rtl/bias_adder_pkg.sv - shared constants, state encoding and saturating add for the bias path
package bias_adder_pkg;

    localparam int CH_NUM = 8;
    localparam int DW     = 32;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREFETCH = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = S_IDLE,
        ST_PREFETCH = S_PREFETCH,
        ST_RUN      = S_RUN,
        ST_DONE     = S_DONE
    } state_e;

    // 33-bit signed sum clipped to the 32-bit signed range
    function automatic logic [DW-1:0] sat_add32(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {a[DW-1], a} + {b[DW-1], b};
        // top two bits disagree only when the result left the 32-bit range
        if (sum[DW] != sum[DW-1]) begin
            sat_add32 = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat_add32 = sum[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/bias_adder_sat_add32.sv
// rtl/bias_adder_sat_add32.sv - combinational 32-bit signed saturating adder
module sat_add32 (
    input  logic [bias_adder_pkg::DW-1:0] a,
    input  logic [bias_adder_pkg::DW-1:0] b,
    output logic [bias_adder_pkg::DW-1:0] sum
);

    assign sum = bias_adder_pkg::sat_add32(a, b);

endmodule

// File: rtl/bias_adder.sv
// rtl/bias_adder.sv - per-group bias fetch and saturating bias add on the accumulator stream
module bias_adder
    import bias_adder_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int GRP_W  = 7
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic                 layer_start,
    input  logic [GRP_W-1:0]     grp_num,
    output logic [GRP_W-1:0]     bias_rd_addr,
    input  logic [DW-1:0]        bias_ch0,
    input  logic [DW-1:0]        bias_ch1,
    input  logic [DW-1:0]        bias_ch2,
    input  logic [DW-1:0]        bias_ch3,
    input  logic [DW-1:0]        bias_ch4,
    input  logic [DW-1:0]        bias_ch5,
    input  logic [DW-1:0]        bias_ch6,
    input  logic [DW-1:0]        bias_ch7,
    input  logic                 acc_vld,
    input  logic                 acc_last,
    input  logic [CH_NUM*DW-1:0] acc_data,
    output logic                 acc_rdy,
    output logic                 out_vld,
    output logic                 out_last,
    output logic [CH_NUM*DW-1:0] out_data,
    output logic                 layer_done,
    output logic                 busy
);

    localparam int WAIT_W = $clog2(RD_LAT + 3);

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [GRP_W-1:0]      grp_num_q, grp_num_d;
    logic [GRP_W-1:0]      grp_cnt_q, grp_cnt_d;
    logic [GRP_W-1:0]      addr_q, addr_d;
    logic [CH_NUM*DW-1:0]  bias_reg_q, bias_reg_d;
    logic [CH_NUM*DW-1:0]  out_data_q, out_data_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_last_q, out_last_d;
    logic                  layer_done_q, layer_done_d;
    logic                  acc_rdy_q, acc_rdy_d;
    logic                  busy_q, busy_d;

    logic [CH_NUM*DW-1:0]  bias_bus;
    logic [CH_NUM*DW-1:0]  sum_w;
    logic                  accept;

    assign bias_bus = {bias_ch7, bias_ch6, bias_ch5, bias_ch4,
                       bias_ch3, bias_ch2, bias_ch1, bias_ch0};

    // acc_rdy_q is only ever high in RUN, so it alone qualifies a beat
    assign accept = acc_vld && acc_rdy_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_sat
        sat_add32 u_sat (
            .a   (acc_data[k*DW +: DW]),
            .b   (bias_reg_q[k*DW +: DW]),
            .sum (sum_w[k*DW +: DW])
        );
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        grp_num_d    = grp_num_q;
        grp_cnt_d    = grp_cnt_q;
        addr_d       = addr_q;
        bias_reg_d   = bias_reg_q;
        out_data_d   = out_data_q;
        out_vld_d    = 1'b0;
        out_last_d   = 1'b0;
        layer_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (layer_start) begin
                    grp_num_d = grp_num;
                    grp_cnt_d = '0;
                    addr_d    = '0;
                    // layer start waits RD_LAT+1 cycles: count 1..RD_LAT+1
                    wait_d    = WAIT_W'(1);
                    state_d   = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                if (wait_q == WAIT_W'(RD_LAT + 1)) begin
                    bias_reg_d = bias_bus;
                    state_d    = ST_RUN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    out_vld_d  = 1'b1;
                    out_last_d = acc_last;
                    out_data_d = sum_w;
                    if (acc_last) begin
                        if (grp_cnt_q == grp_num_q) begin
                            layer_done_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            grp_cnt_d = grp_cnt_q + 1'b1;
                            addr_d    = addr_q + 1'b1;
                            // group switch waits one cycle longer: count 0..RD_LAT+1
                            wait_d    = '0;
                            state_d   = ST_PREFETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        acc_rdy_d = (state_d == ST_RUN);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            grp_num_q    <= '0;
            grp_cnt_q    <= '0;
            addr_q       <= '0;
            bias_reg_q   <= '0;
            out_data_q   <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            layer_done_q <= 1'b0;
            acc_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            grp_num_q    <= grp_num_d;
            grp_cnt_q    <= grp_cnt_d;
            addr_q       <= addr_d;
            bias_reg_q   <= bias_reg_d;
            out_data_q   <= out_data_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            layer_done_q <= layer_done_d;
            acc_rdy_q    <= acc_rdy_d;
            busy_q       <= busy_d;
        end
    end

    assign bias_rd_addr = addr_q;
    assign acc_rdy      = acc_rdy_q;
    assign out_vld      = out_vld_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;
    assign layer_done   = layer_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bias_adder.sv
// tb/tb_bias_adder.sv - randomized self-checking bench for bias_adder
module tb_bias_adder;

    localparam int RD_LAT = 1;
    localparam int GRP_W  = 7;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic             sclk = 1'b0;
    logic             s_rst_n;
    logic             layer_start;
    logic [GRP_W-1:0] grp_num;
    logic [GRP_W-1:0] bias_rd_addr;
    logic             acc_vld;
    logic             acc_last;
    logic [255:0]     acc_data;
    logic             acc_rdy;
    logic             out_vld;
    logic             out_last;
    logic [255:0]     out_data;
    logic             layer_done;
    logic             busy;

    logic [255:0] bias_tab [128];
    logic [255:0] bias_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int tmo          = 0;
    int done_cnt     = 0;

    logic [255:0] got_data_q [$];
    bit           got_last_q [$];
    bit           got_done_q [$];
    logic [255:0] exp_data_q [$];
    bit           exp_last_q [$];
    bit           exp_done_q [$];
    int           obs_addr_q [$];
    int           exp_addr_q [$];
    int           gap_q      [$];

    bias_adder #(.RD_LAT(RD_LAT), .GRP_W(GRP_W)) dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .layer_start  (layer_start),
        .grp_num      (grp_num),
        .bias_rd_addr (bias_rd_addr),
        .bias_ch0     (bias_out[31:0]),
        .bias_ch1     (bias_out[63:32]),
        .bias_ch2     (bias_out[95:64]),
        .bias_ch3     (bias_out[127:96]),
        .bias_ch4     (bias_out[159:128]),
        .bias_ch5     (bias_out[191:160]),
        .bias_ch6     (bias_out[223:192]),
        .bias_ch7     (bias_out[255:224]),
        .acc_vld      (acc_vld),
        .acc_last     (acc_last),
        .acc_data     (acc_data),
        .acc_rdy      (acc_rdy),
        .out_vld      (out_vld),
        .out_last     (out_last),
        .out_data     (out_data),
        .layer_done   (layer_done),
        .busy         (busy)
    );

    always #5 sclk = ~sclk;

    // bias RAM with one cycle of read latency
    always @(posedge sclk) bias_out <= bias_tab[bias_rd_addr];

    always @(negedge sclk) begin
        if (out_vld) begin
            got_data_q.push_back(out_data);
            got_last_q.push_back(out_last);
            got_done_q.push_back(layer_done);
        end
        if (layer_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference: per channel, integer sum clamped to the signed 32-bit range
    function automatic logic [255:0] ref_beat(input logic [255:0] acc, input logic [255:0] bias);
        logic [255:0] r;
        longint s;
        for (int k = 0; k < 8; k++) begin
            s = longint'($signed(acc[32*k +: 32])) + longint'($signed(bias[32*k +: 32]));
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
            r[32*k +: 32] = s[31:0];
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       r[32*k +: 32] = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
                1:       r[32*k +: 32] = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: r[32*k +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    task automatic clear_all();
        got_data_q.delete(); got_last_q.delete(); got_done_q.delete();
        exp_data_q.delete(); exp_last_q.delete(); exp_done_q.delete();
        obs_addr_q.delete(); exp_addr_q.delete(); gap_q.delete();
        done_cnt = 0;
        tmo      = 0;
    endtask

    task automatic start_layer(input int gn);
        layer_start = 1'b1;
        grp_num     = GRP_W'(gn);
        @(negedge sclk);
        layer_start = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input bit last);
        int n;
        n        = 0;
        acc_vld  = 1'b1;
        acc_data = d;
        acc_last = last;
        while (acc_rdy !== 1'b1 && n < 40) begin
            @(negedge sclk);
            n++;
        end
        if (acc_rdy !== 1'b1) tmo++;
        obs_addr_q.push_back(int'(bias_rd_addr));
        @(negedge sclk);
        acc_vld  = 1'b0;
        acc_last = 1'b0;
    endtask

    task automatic wait_gap();
        int gap;
        gap = 0;
        while (acc_rdy !== 1'b1 && gap < 40) begin
            gap++;
            @(negedge sclk);
        end
        gap_q.push_back(gap);
    endtask

    task automatic run_layer(input int gn, input bit inject);
        int           nb;
        bit           last;
        logic [255:0] d;
        start_layer(gn);
        for (int g = 0; g <= gn; g++) begin
            nb = (inject && g == 0) ? 3 : $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                d    = rand_vec();
                last = (b == nb - 1);
                send_beat(d, last);
                exp_data_q.push_back(ref_beat(d, bias_tab[g]));
                exp_last_q.push_back(last);
                exp_done_q.push_back(last && g == gn);
                exp_addr_q.push_back(g);
                if (inject && g == 0 && b == 0) begin
                    layer_start = 1'b1;
                    grp_num     = '0;
                    @(negedge sclk);
                    layer_start = 1'b0;
                end
                if (last && g != gn) wait_gap();
            end
        end
        repeat (4) @(negedge sclk);
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; layer_start = 1'b0; grp_num = '0;
        acc_vld = 1'b0; acc_last = 1'b0; acc_data = '0;
        repeat (3) @(negedge sclk);
        tests_run++; if (bias_rd_addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", bias_rd_addr); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", out_data); end
        tests_run++; if ({acc_rdy, out_vld, out_last, layer_done, busy} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {acc_rdy, out_vld, out_last, layer_done, busy});
        end
        s_rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_single_group();
        logic [255:0] d, e;
        clear_all();
        for (int k = 0; k < 8; k++) begin
            bias_tab[0][32*k +: 32] = 32'(k + 1);
            d[32*k +: 32] = 32'd100;
            e[32*k +: 32] = 32'(101 + k);
        end
        start_layer(0);
        tests_run++; if ({busy, bias_rd_addr} !== {1'b1, 7'd0}) begin tests_failed++; $display("FAIL single_start: busy/addr got %b/%0d expected 1/0", busy, bias_rd_addr); end
        tests_run++; if (acc_rdy !== 1'b0) begin tests_failed++; $display("FAIL single_rdy_t1: got %b expected 0", acc_rdy); end
        @(negedge sclk);
        tests_run++; if (acc_rdy !== 1'b0) begin tests_failed++; $display("FAIL single_rdy_t2: got %b expected 0", acc_rdy); end
        @(negedge sclk);
        tests_run++; if (acc_rdy !== 1'b1) begin tests_failed++; $display("FAIL single_rdy_t3: got %b expected 1", acc_rdy); end
        for (int b = 0; b < 4; b++) send_beat(d, b == 3);
        tests_run++; if ({out_last, layer_done, busy} !== 3'b111) begin tests_failed++; $display("FAIL single_final: last/done/busy got %b expected 111", {out_last, layer_done, busy}); end
        @(negedge sclk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        repeat (3) @(negedge sclk);
        tests_run++; if (got_data_q.size() != 4) begin tests_failed++; $display("FAIL single_count: got %0d expected 4", got_data_q.size()); end
        for (int i = 0; i < 4 && i < got_data_q.size(); i++) begin
            tests_run++; if (got_data_q[i] !== e) begin tests_failed++; $display("FAIL single_data[%0d]: got %h expected %h", i, got_data_q[i], e); end
            tests_run++; if ({got_last_q[i], got_done_q[i]} !== {2{i == 3}}) begin tests_failed++; $display("FAIL single_flags[%0d]: got %b%b", i, got_last_q[i], got_done_q[i]); end
            tests_run++; if (obs_addr_q[i] !== 0) begin tests_failed++; $display("FAIL single_addr[%0d]: got %0d expected 0", i, obs_addr_q[i]); end
        end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
        tests_run++; if (tmo !== 0) begin tests_failed++; $display("FAIL single_timeout: got %0d expected 0", tmo); end
    endtask

    task automatic test_three_groups();
        clear_all();
        for (int g = 0; g < 3; g++) bias_tab[g] = {8{32'(10 * (g + 1))}};
        run_layer(2, 1'b0);
        tests_run++; if (got_data_q.size() != exp_data_q.size()) begin tests_failed++; $display("FAIL three_count: got %0d expected %0d", got_data_q.size(), exp_data_q.size()); end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++; if (got_data_q[i] !== exp_data_q[i]) begin tests_failed++; $display("FAIL three_data[%0d]: got %h expected %h", i, got_data_q[i], exp_data_q[i]); end
            tests_run++; if ({got_last_q[i], got_done_q[i]} !== {exp_last_q[i], exp_done_q[i]}) begin tests_failed++; $display("FAIL three_flags[%0d]: got %b%b expected %b%b", i, got_last_q[i], got_done_q[i], exp_last_q[i], exp_done_q[i]); end
            tests_run++; if (obs_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL three_addr[%0d]: got %0d expected %0d", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++; if (gap_q.size() != 2) begin tests_failed++; $display("FAIL three_gap_count: got %0d expected 2", gap_q.size()); end
        foreach (gap_q[i]) begin
            tests_run++; if (gap_q[i] !== RD_LAT + 2) begin tests_failed++; $display("FAIL three_gap[%0d]: got %0d expected %0d", i, gap_q[i], RD_LAT + 2); end
        end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL three_done_cnt: got %0d expected 1", done_cnt); end
        tests_run++; if (tmo !== 0) begin tests_failed++; $display("FAIL three_timeout: got %0d expected 0", tmo); end
    endtask

    task automatic test_saturation();
        logic [255:0] d0, d1, d2;
        clear_all();
        bias_tab[0] = rand_vec();
        bias_tab[0][31:0]  = 32'h0000_0020;
        bias_tab[0][63:32] = 32'hFFFF_FFE0;
        bias_tab[0][95:64] = 32'd5;
        d0 = rand_vec();
        d0[31:0]  = 32'h7FFF_FFF0;
        d0[63:32] = 32'h8000_0010;
        d0[95:64] = 32'hFFFF_FFFB;
        d1 = rand_vec();
        d2 = rand_vec();
        start_layer(0);
        send_beat(d0, 1'b0);
        send_beat(d1, 1'b0);
        send_beat(d2, 1'b1);
        repeat (4) @(negedge sclk);
        tests_run++; if (got_data_q.size() != 3) begin tests_failed++; $display("FAIL sat_count: got %0d expected 3", got_data_q.size()); end
        if (got_data_q.size() == 3) begin
            tests_run++; if (got_data_q[0][31:0] !== 32'h7FFF_FFFF) begin tests_failed++; $display("FAIL sat_pos: got %h expected 7fffffff", got_data_q[0][31:0]); end
            tests_run++; if (got_data_q[0][63:32] !== 32'h8000_0000) begin tests_failed++; $display("FAIL sat_neg: got %h expected 80000000", got_data_q[0][63:32]); end
            tests_run++; if (got_data_q[0][95:64] !== 32'h0) begin tests_failed++; $display("FAIL sat_zero: got %h expected 0", got_data_q[0][95:64]); end
            tests_run++; if (got_data_q[0] !== ref_beat(d0, bias_tab[0])) begin tests_failed++; $display("FAIL sat_beat0: got %h", got_data_q[0]); end
            tests_run++; if (got_data_q[1] !== ref_beat(d1, bias_tab[0])) begin tests_failed++; $display("FAIL sat_beat1: got %h", got_data_q[1]); end
            tests_run++; if (got_data_q[2] !== ref_beat(d2, bias_tab[0])) begin tests_failed++; $display("FAIL sat_beat2: got %h", got_data_q[2]); end
        end
    endtask

    task automatic test_handshake();
        logic [255:0] d;
        int n;
        clear_all();
        bias_tab[0] = rand_vec();
        d = rand_vec();
        start_layer(0);
        acc_vld = 1'b1; acc_data = d; acc_last = 1'b1;
        n = 0;
        while (acc_rdy !== 1'b1 && n < 40) begin
            tests_run++; if (out_vld !== 1'b0) begin tests_failed++; $display("FAIL hs_early_out[%0d]: got %b expected 0", n, out_vld); end
            @(negedge sclk);
            n++;
        end
        tests_run++; if (n !== RD_LAT + 1) begin tests_failed++; $display("FAIL hs_wait: got %0d cycles expected %0d", n, RD_LAT + 1); end
        // keep the beat presented through DONE and IDLE; it must not be taken again
        repeat (5) @(negedge sclk);
        acc_vld = 1'b0; acc_last = 1'b0;
        repeat (2) @(negedge sclk);
        tests_run++; if (got_data_q.size() != 1) begin tests_failed++; $display("FAIL hs_once: got %0d beats expected 1", got_data_q.size()); end
        if (got_data_q.size() >= 1) begin
            tests_run++; if (got_data_q[0] !== ref_beat(d, bias_tab[0])) begin tests_failed++; $display("FAIL hs_data: got %h expected %h", got_data_q[0], ref_beat(d, bias_tab[0])); end
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL hs_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_start_ignored();
        clear_all();
        for (int g = 0; g < 3; g++) bias_tab[g] = rand_vec();
        run_layer(2, 1'b1);
        tests_run++; if (got_data_q.size() != exp_data_q.size()) begin tests_failed++; $display("FAIL ign_count: got %0d expected %0d", got_data_q.size(), exp_data_q.size()); end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++; if (got_data_q[i] !== exp_data_q[i]) begin tests_failed++; $display("FAIL ign_data[%0d]: got %h expected %h", i, got_data_q[i], exp_data_q[i]); end
            tests_run++; if ({got_last_q[i], got_done_q[i]} !== {exp_last_q[i], exp_done_q[i]}) begin tests_failed++; $display("FAIL ign_flags[%0d]: got %b%b expected %b%b", i, got_last_q[i], got_done_q[i], exp_last_q[i], exp_done_q[i]); end
            tests_run++; if (obs_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL ign_addr[%0d]: got %0d expected %0d", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt); end
        tests_run++; if (tmo !== 0) begin tests_failed++; $display("FAIL ign_timeout: got %0d expected 0", tmo); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        for (int g = 0; g < 3; g++) bias_tab[g] = rand_vec();
        start_layer(2);
        send_beat(rand_vec(), 1'b0);
        send_beat(rand_vec(), 1'b1);
        wait_gap();
        send_beat(rand_vec(), 1'b0);
        s_rst_n = 1'b0;
        #1;
        tests_run++; if (bias_rd_addr !== '0) begin tests_failed++; $display("FAIL rst_mid_addr: got %0d expected 0", bias_rd_addr); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
        tests_run++; if ({acc_rdy, out_vld, out_last, layer_done, busy} !== 5'b0) begin
            tests_failed++; $display("FAIL rst_mid_flags: got %b expected 00000", {acc_rdy, out_vld, out_last, layer_done, busy});
        end
        @(negedge sclk);
        s_rst_n = 1'b1;
        @(negedge sclk);
        clear_all();
        run_layer(1, 1'b0);
        tests_run++; if (got_data_q.size() != exp_data_q.size()) begin tests_failed++; $display("FAIL rst_re_count: got %0d expected %0d", got_data_q.size(), exp_data_q.size()); end
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            tests_run++; if (got_data_q[i] !== exp_data_q[i]) begin tests_failed++; $display("FAIL rst_re_data[%0d]: got %h expected %h", i, got_data_q[i], exp_data_q[i]); end
            tests_run++; if ({got_last_q[i], got_done_q[i]} !== {exp_last_q[i], exp_done_q[i]}) begin tests_failed++; $display("FAIL rst_re_flags[%0d]: got %b%b expected %b%b", i, got_last_q[i], got_done_q[i], exp_last_q[i], exp_done_q[i]); end
            tests_run++; if (obs_addr_q[i] !== exp_addr_q[i]) begin tests_failed++; $display("FAIL rst_re_addr[%0d]: got %0d expected %0d", i, obs_addr_q[i], exp_addr_q[i]); end
        end
        tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL rst_re_done_cnt: got %0d expected 1", done_cnt); end
        tests_run++; if (tmo !== 0) begin tests_failed++; $display("FAIL rst_re_timeout: got %0d expected 0", tmo); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) bias_tab[i] = '0;
        @(negedge sclk);
        test_reset();
        test_single_group();
        test_three_groups();
        test_saturation();
        test_handshake();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
